// File: rtl/inst_uncache_responder.sv
`default_nettype none
// ============================================================================
// Module   : inst_uncache_responder
// Purpose  : Instruction-fetch responder. Accepts pre-IF requests, issues one
//            single-beat AXI read per request, returns words in order, and
//            silently drains in-flight responses after a pipeline cancel.
// Revision : 1.0 - initial release
// ============================================================================
module inst_uncache_responder #(
  parameter int         DEPTH = 2,
  parameter logic [3:0] ARID  = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_cache_valid,
  input  logic        inst_cache_uncache,
  input  logic [19:0] inst_cache_tag,
  input  logic [7:0]  inst_cache_index,
  input  logic [3:0]  inst_cache_offset,
  output logic        inst_cache_addr_ok,
  output logic        inst_cache_data_ok,
  output logic [31:0] inst_cache_rdata,
  input  logic        cancel,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arcache,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_one   = CW'(1);
  localparam logic [PW-1:0] c_ptr_one = PW'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  // Outstanding / drop bookkeeping
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_drop_cnt;

  // Address FIFO of accepted-but-not-yet-handshaken requests: {addr[31:2], uncache}
  logic [30:0]   r_fifo [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_fifo_cnt;

  // AR channel registers
  logic [0:0]  r_state;
  logic        r_arvalid;
  logic [29:0] r_ar_addr;
  logic        r_ar_unc;

  // R channel / response registers
  logic        r_rready;
  logic        r_data_ok;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic [30:0] w_req;
  logic [30:0] w_head1;
  logic        w_load;
  logic [30:0] w_load_entry;
  logic        w_next_arvalid;
  logic [0:0]  w_next_state;
  logic        w_unused;

  // Fields of the request that play no part in the fetch
  assign w_unused = ^{rid, rresp, rlast, inst_cache_offset[1:0]};

  assign w_accept = inst_cache_valid & (r_out_cnt < c_depth) & ~cancel & resetn;
  assign w_ar_hs  = r_arvalid & arready;
  assign w_r_hs   = rvalid & r_rready;
  assign w_req    = {inst_cache_tag, inst_cache_index, inst_cache_offset[3:2], inst_cache_uncache};
  assign w_head1  = r_fifo[r_rd_ptr + c_ptr_one];

  assign inst_cache_addr_ok = w_accept;
  assign inst_cache_data_ok = r_data_ok;
  assign inst_cache_rdata   = r_rdata;
  assign arid    = ARID;
  assign araddr  = {r_ar_addr, 2'b00};
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arcache = r_ar_unc ? 4'b0000 : 4'b1111;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  // AR next-state: load the next request to present, falling back to the one
  // arriving this cycle so a fresh request reaches AR one cycle after accept
  always_comb begin
    w_next_state   = r_state;
    w_next_arvalid = r_arvalid;
    w_load         = 1'b0;
    w_load_entry   = w_req;
    case (r_state)
      S_IDLE: begin
        if (r_fifo_cnt != '0) begin
          w_load       = 1'b1;
          w_load_entry = r_fifo[r_rd_ptr];
        end else if (w_accept) begin
          w_load = 1'b1;
        end
        if (w_load) begin
          w_next_state   = S_ISSUE;
          w_next_arvalid = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_ar_hs) begin
          if (r_fifo_cnt > c_one) begin
            w_load       = 1'b1;
            w_load_entry = w_head1;
          end else if (w_accept) begin
            w_load = 1'b1;
          end else begin
            w_next_state   = S_IDLE;
            w_next_arvalid = 1'b0;
          end
        end
      end
      default: begin
        w_next_state   = S_IDLE;
        w_next_arvalid = 1'b0;
      end
    endcase
  end

  // AR channel state and held address fields
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_arvalid <= 1'b0;
      r_ar_addr <= '0;
      r_ar_unc  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_arvalid <= w_next_arvalid;
      if (w_load) begin
        {r_ar_addr, r_ar_unc} <= w_load_entry;
      end
    end
  end

  // FIFO storage: written on accept, no reset needed
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fifo[r_wr_ptr] <= w_req;
    end
  end

  // FIFO pointers and occupancy; entries leave on the AR handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_ar_hs)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_accept, w_ar_hs})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + c_one;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - c_one;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Outstanding count and the number of responses still to be swallowed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      case ({w_accept, w_r_hs})
        2'b10:   r_out_cnt <= r_out_cnt + c_one;
        2'b01:   r_out_cnt <= r_out_cnt - c_one;
        default: r_out_cnt <= r_out_cnt;
      endcase
      if (cancel) begin
        r_drop_cnt <= r_out_cnt - CW'(w_r_hs);
      end else if (w_r_hs && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - c_one;
      end
    end
  end

  // Response path: capture the word and pulse data_ok unless it is being dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rready  <= 1'b0;
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rready  <= 1'b1;
      r_data_ok <= w_r_hs & ~cancel & (r_drop_cnt == '0);
      if (w_r_hs && !cancel && (r_drop_cnt == '0)) begin
        r_rdata <= rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_uncache_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_uncache_responder
// Purpose  : Randomised and directed bench with an AXI slave model, a
//            request-level reference model and a data_ok scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_uncache_responder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_cache_valid = 1'b0;
  logic        inst_cache_uncache = 1'b0;
  logic [19:0] inst_cache_tag = '0;
  logic [7:0]  inst_cache_index = '0;
  logic [3:0]  inst_cache_offset = '0;
  logic        inst_cache_addr_ok;
  logic        inst_cache_data_ok;
  logic [31:0] inst_cache_rdata;
  logic        cancel = 1'b0;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  logic        rready;

  inst_uncache_responder #(.DEPTH(DEPTH), .ARID(4'd0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_cache_valid(inst_cache_valid), .inst_cache_uncache(inst_cache_uncache),
    .inst_cache_tag(inst_cache_tag), .inst_cache_index(inst_cache_index),
    .inst_cache_offset(inst_cache_offset), .inst_cache_addr_ok(inst_cache_addr_ok),
    .inst_cache_data_ok(inst_cache_data_ok), .inst_cache_rdata(inst_cache_rdata),
    .cancel(cancel),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  // Reference model state
  bit          outst[$];      // one entry per accepted request, 1 = data will be delivered
  logic [35:0] exp_ar[$];     // {araddr, arcache} expected on AR, in order
  logic [31:0] exp_data[$];   // words expected on data_ok, in order
  pend_t       pend[$];       // AXI slave: accepted reads waiting to return
  logic [31:0] data_q[$];     // preset read data for directed tests

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dok_count = 0;
  int last_dok_cyc = 0;
  int ar_pct = 100;
  int dmin = 1;
  int dmax = 1;
  bit          ar_wait = 0;
  logic [31:0] held_addr;
  logic [3:0]  held_cache;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
    check({tag, "_araddr"}, araddr, 32'd0);
    check({tag, "_data_ok"}, {31'd0, inst_cache_data_ok}, 32'd0);
    check({tag, "_rdata"}, inst_cache_rdata, 32'd0);
    check({tag, "_addr_ok"}, {31'd0, inst_cache_addr_ok}, 32'd0);
    check({tag, "_rready"}, {31'd0, rready}, 32'd0);
  endtask

  // One clock cycle: drive inputs, then evaluate everything the coming edge will see
  task automatic cycle(input logic v, input logic unc, input logic [31:0] a, input logic cn);
    bit          exp_ok;
    bit          keep;
    logic [35:0] ar_e;
    pend_t       p;
    @(negedge clk);
    cyc++;
    inst_cache_valid   = v;
    inst_cache_uncache = unc;
    inst_cache_tag     = a[31:12];
    inst_cache_index   = a[11:4];
    inst_cache_offset  = a[3:0];
    cancel             = cn;
    arready = ($urandom_range(0, 99) < ar_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = pend[0].data;
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    #1;
    if (ar_wait) begin
      check("ar_hold_valid", {31'd0, arvalid}, 32'd1);
      check("ar_hold_addr", araddr, held_addr);
      check("ar_hold_cache", {28'd0, arcache}, {28'd0, held_cache});
    end
    exp_ok = v && (outst.size() < DEPTH) && !cn;
    check("addr_ok", {31'd0, inst_cache_addr_ok}, {31'd0, exp_ok});
    if (arvalid && arready) begin
      if (exp_ar.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ar_unexpected: got araddr %h with no request pending", araddr);
      end else begin
        ar_e = exp_ar.pop_front();
        check("araddr", araddr, ar_e[35:4]);
        check("arcache", {28'd0, arcache}, {28'd0, ar_e[3:0]});
        check("arlen", {24'd0, arlen}, 32'd0);
        check("arsize", {29'd0, arsize}, 32'd2);
        check("arburst", {30'd0, arburst}, 32'd1);
        check("arid", {28'd0, arid}, 32'd0);
      end
      p.due  = cyc + $urandom_range(dmin, dmax);
      p.data = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
      pend.push_back(p);
    end
    ar_wait    = arvalid && !arready;
    held_addr  = araddr;
    held_cache = arcache;
    if (rvalid) begin
      check("rready", {31'd0, rready}, 32'd1);
      if (rready) begin
        void'(pend.pop_front());
        keep = (outst.size() > 0) ? outst.pop_front() : 1'b0;
        if (keep && !cn) exp_data.push_back(rdata);
      end
    end
    if (cn) foreach (outst[i]) outst[i] = 1'b0;
    if (exp_ok) begin
      outst.push_back(1'b1);
      exp_ar.push_back({a[31:2], 2'b00, (unc ? 4'b0000 : 4'b1111)});
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((outst.size() > 0 || exp_data.size() > 0 || pend.size() > 0) && k < 300) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      k++;
    end
    if (k >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d requests still outstanding after %0d cycles", outst.size(), k);
    end
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // Scoreboard monitor: every data_ok must match the oldest expected word
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (resetn === 1'b1 && inst_cache_data_ok === 1'b1) begin
        dok_count++;
        last_dok_cyc = cyc;
        if (exp_data.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL data_ok_unexpected: got rdata %h with nothing expected", inst_cache_rdata);
        end else begin
          check("rdata", inst_cache_rdata, exp_data.pop_front());
        end
      end
    end
  end

  initial begin
    int t_acc;
    int d0;
    resetn = 1'b0;
    inst_cache_valid = 1'b1;
    #3;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    inst_cache_valid = 1'b0;
    resetn = 1'b1;

    // Single uncached fetch with fixed timing
    ar_pct = 100; dmin = 2; dmax = 2;
    data_q.push_back(32'h3C1D8000);
    cycle(1'b1, 1'b1, 32'h1FC00000, 1'b0);
    t_acc = cyc;
    drain();
    check("single_latency", last_dok_cyc - t_acc, 32'd4);

    // Back-to-back with slow returns: addr_ok only while slots are free
    dmin = 5; dmax = 5;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h00010000 + 32'(i * 4), 1'b0);
    drain();

    // arready held low four cycles: AR must hold, offset[1:0] cleared
    ar_pct = 0; dmin = 1; dmax = 1;
    cycle(1'b1, 1'b0, 32'h00400006, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    ar_pct = 100;
    drain();

    // Cancel with two outstanding: only the later request returns data
    dmin = 6; dmax = 6;
    data_q.push_back(32'h11111111);
    data_q.push_back(32'h22222222);
    data_q.push_back(32'h33333333);
    d0 = dok_count;
    cycle(1'b1, 1'b1, 32'h1FC00020, 1'b0);
    cycle(1'b1, 1'b1, 32'h1FC00024, 1'b0);
    cycle(1'b1, 1'b1, 32'h1FC00028, 1'b0);
    cycle(1'b1, 1'b1, 32'h1FC0002C, 1'b1);
    drain();
    dmin = 2; dmax = 2;
    cycle(1'b1, 1'b0, 32'hBFC00010, 1'b0);
    drain();
    check("cancel_dok_count", dok_count - d0, 32'd1);

    // Asynchronous reset while a request is presented and two are outstanding
    ar_pct = 0;
    cycle(1'b1, 1'b0, 32'h00000100, 1'b0);
    cycle(1'b1, 1'b0, 32'h00000104, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    inst_cache_valid = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid");
    outst.delete(); exp_ar.delete(); pend.delete(); exp_data.delete(); data_q.delete();
    ar_wait = 0;
    repeat (2) @(negedge clk);
    inst_cache_valid = 1'b0;
    arready = 1'b0;
    rvalid = 1'b0;
    resetn = 1'b1;
    ar_pct = 100; dmin = 1; dmax = 3;
    d0 = dok_count;
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 32'h1FC00040, 1'b0);
    drain();
    check("post_reset_dok_count", dok_count - d0, 32'd1);

    // Randomised traffic with random backpressure, latency and cancels
    ar_pct = 60; dmin = 1; dmax = 4;
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) < 70), 1'($urandom), $urandom, ($urandom_range(0, 99) < 4));
    end
    ar_pct = 100;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
